// File: rtl/core_dispatcher.sv
// Dispatcher between the event priority queue and the processing cores: issues queued events to idle
// cores, returns core results to the queue round-robin, and reports every transfer to the core monitor.
module core_dispatcher #(
    parameter int NUM_CORE = 4,
    parameter int MSG_WID  = 32,
    parameter int TIME_WID = 16,
    localparam int ID_W    = $clog2(NUM_CORE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         q_empty,
    input  logic [MSG_WID-1:0]           q_head,
    output logic                         q_deq,
    input  logic                         q_full,
    output logic                         q_enq,
    output logic [MSG_WID-1:0]           q_enq_data,
    input  logic [NUM_CORE-1:0]          core_req,
    input  logic [NUM_CORE*MSG_WID-1:0]  core_data,
    output logic [NUM_CORE-1:0]          core_ack,
    output logic [NUM_CORE-1:0]          core_start,
    output logic [MSG_WID-1:0]           core_msg,
    output logic [MSG_WID-1:0]           mon_msg,
    output logic                         mon_sent_vld,
    output logic                         mon_rcv_vld,
    output logic [ID_W-1:0]              mon_core_id,
    output logic [NUM_CORE-1:0]          core_active,
    output logic                         err_unexp
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RECV} state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  prio_q, prio_d;
    logic                  err_q, err_d;
    logic [NUM_CORE-1:0]   active_q, active_d;
    logic                  q_deq_q, q_deq_d;
    logic                  q_enq_q, q_enq_d;
    logic [MSG_WID-1:0]    enq_data_q, enq_data_d;
    logic [MSG_WID-1:0]    core_msg_q, core_msg_d;
    logic [MSG_WID-1:0]    mon_msg_q, mon_msg_d;
    logic [NUM_CORE-1:0]   ack_q, ack_d;
    logic [NUM_CORE-1:0]   start_q, start_d;
    logic                  sent_q, sent_d;
    logic                  rcv_q, rcv_d;
    logic [ID_W-1:0]       mon_id_q, mon_id_d;

    logic [MSG_WID-1:0]    data_arr [NUM_CORE];
    logic [NUM_CORE-1:0]   act_req;
    logic                  can_rcv, can_send, go_rcv;
    logic                  rcv_found, send_found;
    logic [ID_W-1:0]       rcv_id, send_id, idx;

    // Timestamps live in the low TIME_WID bits of a message and pass through untouched.
    if (TIME_WID > MSG_WID) begin : g_time_exceeds_msg
    end

    always_comb begin
        act_req    = core_req & active_q;
        can_rcv    = (|act_req) && !q_full;
        can_send   = !q_empty && (|(~active_q));
        go_rcv     = can_rcv && (!can_send || !prio_q);
        rcv_id     = '0;
        rcv_found  = 1'b0;
        send_id    = '0;
        send_found = 1'b0;
        idx        = '0;
        for (int k = 0; k < NUM_CORE; k++) begin
            data_arr[k] = core_data[k*MSG_WID +: MSG_WID];
        end
        // Index arithmetic wraps naturally because NUM_CORE is a power of two.
        for (int k = 0; k < NUM_CORE; k++) begin
            idx = rr_ptr_q + ID_W'(k);
            if (!rcv_found && act_req[idx]) begin
                rcv_id    = idx;
                rcv_found = 1'b1;
            end
        end
        for (int k = 0; k < NUM_CORE; k++) begin
            if (!send_found && !active_q[k]) begin
                send_id    = ID_W'(k);
                send_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        prio_d     = prio_q;
        err_d      = err_q | (|(core_req & ~active_q));
        active_d   = active_q;
        q_deq_d    = 1'b0;
        q_enq_d    = 1'b0;
        enq_data_d = enq_data_q;
        core_msg_d = core_msg_q;
        mon_msg_d  = mon_msg_q;
        ack_d      = '0;
        start_d    = '0;
        sent_d     = 1'b0;
        rcv_d      = 1'b0;
        mon_id_d   = mon_id_q;
        case (state_q)
            ST_IDLE: begin
                if (can_rcv && can_send) prio_d = go_rcv;
                if (go_rcv) begin
                    state_d         = ST_RECV;
                    rr_ptr_d        = rcv_id + ID_W'(1);
                    q_enq_d         = 1'b1;
                    enq_data_d      = data_arr[rcv_id];
                    mon_msg_d       = data_arr[rcv_id];
                    ack_d[rcv_id]   = 1'b1;
                    rcv_d           = 1'b1;
                    mon_id_d        = rcv_id;
                end else if (can_send) begin
                    state_d          = ST_SEND;
                    q_deq_d          = 1'b1;
                    core_msg_d       = q_head;
                    mon_msg_d        = q_head;
                    start_d[send_id] = 1'b1;
                    sent_d           = 1'b1;
                    mon_id_d         = send_id;
                end
            end
            // The core involved in the current op is still held in mon_id_q.
            ST_SEND: begin
                active_d[mon_id_q] = 1'b1;
                state_d            = ST_IDLE;
            end
            ST_RECV: begin
                active_d[mon_id_q] = 1'b0;
                state_d            = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            prio_q     <= 1'b0;
            err_q      <= 1'b0;
            active_q   <= '0;
            q_deq_q    <= 1'b0;
            q_enq_q    <= 1'b0;
            enq_data_q <= '0;
            core_msg_q <= '0;
            mon_msg_q  <= '0;
            ack_q      <= '0;
            start_q    <= '0;
            sent_q     <= 1'b0;
            rcv_q      <= 1'b0;
            mon_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            prio_q     <= prio_d;
            err_q      <= err_d;
            active_q   <= active_d;
            q_deq_q    <= q_deq_d;
            q_enq_q    <= q_enq_d;
            enq_data_q <= enq_data_d;
            core_msg_q <= core_msg_d;
            mon_msg_q  <= mon_msg_d;
            ack_q      <= ack_d;
            start_q    <= start_d;
            sent_q     <= sent_d;
            rcv_q      <= rcv_d;
            mon_id_q   <= mon_id_d;
        end
    end

    assign q_deq        = q_deq_q;
    assign q_enq        = q_enq_q;
    assign q_enq_data   = enq_data_q;
    assign core_ack     = ack_q;
    assign core_start   = start_q;
    assign core_msg     = core_msg_q;
    assign mon_msg      = mon_msg_q;
    assign mon_sent_vld = sent_q;
    assign mon_rcv_vld  = rcv_q;
    assign mon_core_id  = mon_id_q;
    assign core_active  = active_q;
    assign err_unexp    = err_q;

endmodule

// File: tb/tb_core_dispatcher.sv
// Bench for core_dispatcher: a queue/core environment plus a transaction-level reference model that
// predicts each cycle's operation from the arbitration rules.
module tb_core_dispatcher;

    localparam int NC = 4;
    localparam int MW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            q_empty;
    logic [MW-1:0]   q_head;
    logic            q_deq;
    logic            q_full;
    logic            q_enq;
    logic [MW-1:0]   q_enq_data;
    logic [NC-1:0]   core_req;
    logic [NC*MW-1:0] core_data;
    logic [NC-1:0]   core_ack;
    logic [NC-1:0]   core_start;
    logic [MW-1:0]   core_msg;
    logic [MW-1:0]   mon_msg;
    logic            mon_sent_vld;
    logic            mon_rcv_vld;
    logic [1:0]      mon_core_id;
    logic [NC-1:0]   core_active;
    logic            err_unexp;

    core_dispatcher #(.NUM_CORE(NC), .MSG_WID(MW), .TIME_WID(16)) dut (
        .clk(clk), .reset(reset), .q_empty(q_empty), .q_head(q_head), .q_deq(q_deq),
        .q_full(q_full), .q_enq(q_enq), .q_enq_data(q_enq_data), .core_req(core_req),
        .core_data(core_data), .core_ack(core_ack), .core_start(core_start), .core_msg(core_msg),
        .mon_msg(mon_msg), .mon_sent_vld(mon_sent_vld), .mon_rcv_vld(mon_rcv_vld),
        .mon_core_id(mon_core_id), .core_active(core_active), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Environment: queue contents and per-core behaviour
    logic [MW-1:0] evq[$];
    bit            full_v;
    bit [NC-1:0]   req_v;
    logic [MW-1:0] res_v [NC];
    bit            held [NC];
    int            timer [NC];
    bit            auto_resp;
    int            max_delay;

    // Reference model: busy set, round-robin pointer, priority, predicted op (0 none, 1 send, 2 recv)
    bit [NC-1:0]   m_busy;
    int            m_rr;
    bit            m_prio;
    bit            e_err;
    int            e_op, e_id, h_id;
    logic [MW-1:0] e_msg, h_msg;

    function automatic logic [114:0] outs();
        return {q_deq, q_enq, q_enq_data, core_ack, core_start, core_msg, mon_msg,
                mon_sent_vld, mon_rcv_vld, mon_core_id, core_active, err_unexp};
    endfunction

    task automatic drive_pins();
        q_empty = (evq.size() == 0);
        q_head  = q_empty ? '0 : evq[0];
        q_full  = full_v;
        core_req = req_v;
        for (int i = 0; i < NC; i++) core_data[i*MW +: MW] = res_v[i];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        evq.delete();
        full_v = 0; req_v = '0; auto_resp = 0; max_delay = 0;
        for (int i = 0; i < NC; i++) begin held[i] = 0; timer[i] = 0; res_v[i] = '0; end
        m_busy = '0; m_rr = 0; m_prio = 0; e_err = 0;
        e_op = 0; e_id = 0; h_id = 0; e_msg = '0; h_msg = '0;
        drive_pins();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Predict the next cycle, advance one clock, then let queue and cores react to the DUT.
    task automatic tick();
        bit can_rcv, can_send, do_rcv;
        int r;
        drive_pins();
        e_err = e_err | (|(req_v & ~m_busy));
        if (e_op == 1) m_busy[e_id] = 1'b1;
        else if (e_op == 2) m_busy[e_id] = 1'b0;
        if (e_op != 0) begin
            e_op = 0;
        end else begin
            can_rcv  = (|(req_v & m_busy)) && !full_v;
            can_send = (evq.size() != 0) && (m_busy != '1);
            do_rcv   = can_rcv && (!can_send || !m_prio);
            if (can_rcv && can_send) m_prio = do_rcv;
            if (do_rcv) begin
                r = m_rr;
                while (!(req_v[r] && m_busy[r])) r = (r + 1) % NC;
                e_op = 2; e_id = r; e_msg = res_v[r]; m_rr = (r + 1) % NC;
            end else if (can_send) begin
                r = 0;
                while (m_busy[r]) r++;
                e_op = 1; e_id = r; e_msg = evq[0];
            end
            if (e_op != 0) begin h_id = e_id; h_msg = e_msg; end
        end
        @(negedge clk);
        if (q_deq === 1'b1 && evq.size() != 0) void'(evq.pop_front());
        for (int i = 0; i < NC; i++) begin
            if (core_ack[i] === 1'b1) begin
                req_v[i] = 0; held[i] = 0;
            end else if (held[i] && !req_v[i] && auto_resp) begin
                if (timer[i] == 0) begin req_v[i] = 1; res_v[i] = $urandom; end
                else timer[i]--;
            end
            if (core_start[i] === 1'b1) begin
                held[i] = 1; timer[i] = $urandom_range(max_delay, 0);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (outs() !== '0) begin n_errors++; $display("FAIL reset_outputs got %0h want 0", outs()); end
        repeat (3) tick();
        n_checks++;
        if (outs() !== '0) begin n_errors++; $display("FAIL idle_no_work got %0h want 0", outs()); end
    endtask

    task automatic test_first_send();
        do_reset();
        evq.push_back(32'h0000_0005);
        tick();
        n_checks++;
        if ({core_start, mon_sent_vld, mon_core_id, q_deq, mon_rcv_vld} !== {4'b0001, 1'b1, 2'd0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL first_send_strobes got start=%b sent=%b id=%0d deq=%b rcv=%b want 0001 1 0 1 0",
                     core_start, mon_sent_vld, mon_core_id, q_deq, mon_rcv_vld);
        end
        n_checks++;
        if (core_msg !== 32'h5 || mon_msg !== 32'h5) begin
            n_errors++; $display("FAIL first_send_msg got core=%0h mon=%0h want 5", core_msg, mon_msg);
        end
        tick();
        n_checks++;
        if ({core_active, q_deq, mon_sent_vld, mon_core_id, mon_msg} !== {4'b0001, 1'b0, 1'b0, 2'd0, 32'h5}) begin
            n_errors++;
            $display("FAIL first_send_after got active=%b deq=%b sent=%b id=%0d msg=%0h want 0001 0 0 0 5",
                     core_active, q_deq, mon_sent_vld, mon_core_id, mon_msg);
        end
    endtask

    task automatic test_fill();
        logic [MW-1:0] ev [5];
        int nsent, ndeq;
        do_reset();
        for (int i = 0; i < 5; i++) begin ev[i] = $urandom; evq.push_back(ev[i]); end
        nsent = 0; ndeq = 0;
        repeat (12) begin
            tick();
            if (q_deq === 1'b1) ndeq++;
            if (mon_sent_vld === 1'b1) begin
                n_checks++;
                if (nsent >= 4 || mon_core_id !== 2'(nsent) || core_msg !== ev[nsent]) begin
                    n_errors++;
                    $display("FAIL fill_order got id=%0d msg=%0h want id=%0d (send #%0d)", mon_core_id, core_msg, nsent, nsent);
                end
                nsent++;
            end
        end
        n_checks++;
        if (nsent != 4 || ndeq != 4) begin
            n_errors++; $display("FAIL fill_count got sends=%0d deqs=%0d want 4 4", nsent, ndeq);
        end
        n_checks++;
        if (core_active !== 4'b1111 || evq.size() != 1) begin
            n_errors++; $display("FAIL fill_state got active=%b left=%0d want 1111 1", core_active, evq.size());
        end
    endtask

    task automatic test_rr();
        int exp_id [2];
        logic [MW-1:0] exp_d [2];
        int nr;
        exp_id[0] = 1; exp_id[1] = 3;
        do_reset();
        repeat (4) evq.push_back($urandom);
        repeat (8) tick();
        exp_d[0] = $urandom; exp_d[1] = $urandom;
        res_v[1] = exp_d[0]; res_v[3] = exp_d[1];
        req_v[1] = 1; req_v[3] = 1;
        nr = 0;
        repeat (8) begin
            tick();
            if (core_ack !== 4'b0000) begin
                n_checks++;
                if (nr >= 2 || core_ack !== 4'(1 << exp_id[nr]) || mon_core_id !== 2'(exp_id[nr]) ||
                    q_enq !== 1'b1 || q_enq_data !== exp_d[nr] || mon_msg !== exp_d[nr] || mon_rcv_vld !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rr_recv got ack=%b id=%0d enq=%b data=%0h want ack of core %0d data=%0h",
                             core_ack, mon_core_id, q_enq, q_enq_data, (nr < 2) ? exp_id[nr] : -1, (nr < 2) ? exp_d[nr] : '0);
                end
                nr++;
            end
        end
        n_checks++;
        if (nr != 2 || core_active !== 4'b0101) begin
            n_errors++; $display("FAIL rr_final got recvs=%0d active=%b want 2 0101", nr, core_active);
        end
    endtask

    task automatic test_qfull();
        logic [MW-1:0] d;
        bit got;
        do_reset();
        repeat (2) evq.push_back($urandom);
        repeat (4) tick();
        d = $urandom;
        full_v = 1; res_v[0] = d; req_v[0] = 1;
        repeat (10) begin
            tick();
            n_checks++;
            if ({q_enq, core_ack} !== 5'b0) begin
                n_errors++; $display("FAIL qfull_blocked got enq=%b ack=%b want 0 0000", q_enq, core_ack);
            end
        end
        full_v = 0; got = 0;
        repeat (3) begin
            tick();
            if (q_enq === 1'b1 && !got) begin
                got = 1;
                n_checks++;
                if (mon_core_id !== 2'd0 || q_enq_data !== d || core_ack !== 4'b0001) begin
                    n_errors++; $display("FAIL qfull_release got id=%0d data=%0h ack=%b want 0 %0h 0001", mon_core_id, q_enq_data, core_ack, d);
                end
            end
        end
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL qfull_timeout got no enq want enq within 3 cycles"); end
    endtask

    task automatic test_prio();
        int ops [8];
        int exp_ops [4];
        int n;
        exp_ops[0] = 2; exp_ops[1] = 1; exp_ops[2] = 2; exp_ops[3] = 1;
        do_reset();
        repeat (2) evq.push_back($urandom);
        repeat (4) tick();
        res_v[0] = $urandom; res_v[1] = $urandom; req_v = 4'b0011;
        repeat (6) evq.push_back($urandom);
        auto_resp = 1; max_delay = 0;
        n = 0;
        repeat (8) begin
            tick();
            if (mon_sent_vld === 1'b1) begin ops[n] = 1; n++; end
            else if (mon_rcv_vld === 1'b1) begin ops[n] = 2; n++; end
        end
        n_checks++;
        if (n < 4) begin n_errors++; $display("FAIL prio_count got %0d ops want 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            n_checks++;
            if (ops[i] != exp_ops[i]) begin
                n_errors++; $display("FAIL prio_order op%0d got %0d want %0d (1=send 2=recv)", i, ops[i], exp_ops[i]);
            end
        end
    endtask

    task automatic test_err_and_reset();
        do_reset();
        req_v[2] = 1; res_v[2] = 32'hBAD0_0002;
        n_checks++;
        if (err_unexp !== 1'b0) begin n_errors++; $display("FAIL err_initial got %b want 0", err_unexp); end
        repeat (4) begin
            tick();
            n_checks++;
            if (core_ack !== 4'b0 || err_unexp !== 1'b1) begin
                n_errors++; $display("FAIL err_set got ack=%b err=%b want 0000 1", core_ack, err_unexp);
            end
        end
        req_v = '0;
        repeat (3) tick();
        n_checks++;
        if (err_unexp !== 1'b1) begin n_errors++; $display("FAIL err_sticky got %b want 1", err_unexp); end
        evq.push_back(32'hDEAD_BEEF);
        tick();
        n_checks++;
        if (mon_sent_vld !== 1'b1) begin n_errors++; $display("FAIL mid_send_setup got sent=%b want 1", mon_sent_vld); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (outs() !== '0) begin n_errors++; $display("FAIL reset_mid_send got %0h want 0", outs()); end
        do_reset();
        n_checks++;
        if (outs() !== '0) begin n_errors++; $display("FAIL reset_after got %0h want 0", outs()); end
    endtask

    task automatic test_random();
        logic [11:0] exp_s, act_s;
        do_reset();
        auto_resp = 1; max_delay = 6;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (evq.size() < 8 && $urandom_range(2, 0) == 0) evq.push_back($urandom);
            full_v = ($urandom_range(4, 0) == 0);
            tick();
            exp_s = '0;
            if (e_op == 1) begin exp_s[11] = 1; exp_s[9] = 1; exp_s[4 + e_id] = 1; end
            if (e_op == 2) begin exp_s[10] = 1; exp_s[8] = 1; exp_s[e_id] = 1; end
            act_s = {q_deq, q_enq, mon_sent_vld, mon_rcv_vld, core_start, core_ack};
            n_checks++;
            if (act_s !== exp_s) begin
                n_errors++; $display("FAIL rand_strobes cyc %0d got %b want %b", cyc, act_s, exp_s);
            end
            n_checks++;
            if (mon_core_id !== 2'(h_id) || mon_msg !== h_msg) begin
                n_errors++; $display("FAIL rand_mon cyc %0d got id=%0d msg=%0h want id=%0d msg=%0h", cyc, mon_core_id, mon_msg, h_id, h_msg);
            end
            n_checks++;
            if (core_active !== m_busy || err_unexp !== e_err) begin
                n_errors++; $display("FAIL rand_state cyc %0d got active=%b err=%b want %b %b", cyc, core_active, err_unexp, m_busy, e_err);
            end
            if (e_op == 1) begin
                n_checks++;
                if (core_msg !== e_msg) begin n_errors++; $display("FAIL rand_core_msg cyc %0d got %0h want %0h", cyc, core_msg, e_msg); end
            end
            if (e_op == 2) begin
                n_checks++;
                if (q_enq_data !== e_msg) begin n_errors++; $display("FAIL rand_enq_data cyc %0d got %0h want %0h", cyc, q_enq_data, e_msg); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_first_send();
        test_fill();
        test_rr();
        test_qfull();
        test_prio();
        test_err_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
